afc_bsearch_ctrl: RTL and testbench

Binary-search controller of the automatic frequency calibrator. It consumes one comparison result per measurement window from the upstream ref/div counter-comparator stage (`ref_fast`, `div_fast`, `eq`). It drives the VCO control code one bit per window, MSB first, and asserts lock status when the search completes. It runs entirely in the `refclk` domain and sits between the counter-comparator stage and the VCO code output of `afc_top`.

---
 rtl/afc_pkg.sv | 36 +++
 rtl/afc_settle_timer.sv | 27 ++
 rtl/afc_bsearch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_afc_bsearch_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/afc_pkg.sv
// Shared types and helpers for the AFC binary-search controller and comparator stage.
package afc_pkg;

  typedef enum logic [1:0] {
    AFC_IDLE,
    AFC_SETTLE,
    AFC_MEASURE,
    AFC_DONE
  } afc_state_t;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_DIV_FAST,
    CMP_REF_FAST
  } afc_cmp_t;

  // Bit position of the search midpoint (the first trial bit).
  function automatic int unsigned afc_mid_bit(input int unsigned width);
    return width - 1;
  endfunction

  // Bits needed to hold values 0 .. n-1 (at least one).
  function automatic int unsigned afc_cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Priority eq > div_fast > ref_fast; a result with no flag set counts as ref_fast.
  function automatic afc_cmp_t afc_cmp_decode(input logic eq, input logic div_fast,
                                              input logic ref_fast);
    if (eq)            return CMP_EQ;
    else if (div_fast) return CMP_DIV_FAST;
    else if (ref_fast) return CMP_REF_FAST;
    else               return CMP_REF_FAST;
  endfunction

endpackage

// File: rtl/afc_settle_timer.sv
// Loadable down-counter; zero_o flags the terminal count and the counter parks there.
module afc_settle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/afc_bsearch_ctrl.sv
// AFC binary-search controller: one VCO code bit per measurement window, MSB first.
// Define AFC_TIMEOUT_EN to add the MEASURE watchdog that aborts with afc_fail.
module afc_bsearch_ctrl
  import afc_pkg::*;
#(
  parameter int unsigned CODE_WIDTH     = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  afctrigger,
  input  logic                  cmp_valid,
  input  logic                  ref_fast,
  input  logic                  div_fast,
  input  logic                  eq,
  output logic                  meas_start,
  output logic [CODE_WIDTH-1:0] control_code_out,
  output logic                  afc_status,
  output logic                  afc_busy,
  output logic                  afc_fail
);

  localparam int unsigned KW = afc_cnt_width(CODE_WIDTH);
`ifdef AFC_TIMEOUT_EN
  localparam int unsigned TW = afc_cnt_width((SETTLE_CYCLES > TIMEOUT_CYCLES + 1) ?
                                             SETTLE_CYCLES : TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
`else
  localparam int unsigned TW = afc_cnt_width(SETTLE_CYCLES);
`endif
  localparam logic [TW-1:0]         SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [CODE_WIDTH-1:0] MID_CODE    = CODE_WIDTH'(1) << afc_mid_bit(CODE_WIDTH);
  localparam logic [KW-1:0]         K_INIT      = KW'(CODE_WIDTH - 1);

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("afc_bsearch_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  afc_state_t            state_q, state_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  meas_q, meas_d;
  logic                  status_q, status_d;
  logic                  busy_q, busy_d;
  logic                  fail_d;
  logic                  tmr_load, tmr_zero;
  logic [TW-1:0]         tmr_val;
  afc_cmp_t              cmp;

  // One timer serves both waits: SETTLE length on each code update, watchdog on entry to MEASURE.
  afc_settle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk_i      (refclk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

`ifdef AFC_TIMEOUT_EN
  logic fail_q;
`else
  logic fail_q;
  assign fail_q = 1'b0;
`endif

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= AFC_IDLE;
      code_q   <= MID_CODE;
      k_q      <= K_INIT;
      meas_q   <= 1'b0;
      status_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      k_q      <= k_d;
      meas_q   <= meas_d;
      status_q <= status_d;
      busy_q   <= busy_d;
    end
  end

`ifdef AFC_TIMEOUT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) fail_q <= 1'b0;
    else        fail_q <= fail_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    k_d      = k_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LOAD;
    cmp      = afc_cmp_decode(eq, div_fast, ref_fast);
    unique case (state_q)
      AFC_IDLE: begin
        if (afctrigger) begin
          state_d  = AFC_SETTLE;
          code_d   = MID_CODE;
          k_d      = K_INIT;
          fail_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end
      AFC_SETTLE: begin
        if (!afctrigger) begin
          state_d = AFC_IDLE;
        end else if (tmr_zero) begin
          state_d = AFC_MEASURE;
`ifdef AFC_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LOAD;
`endif
        end
      end
      AFC_MEASURE: begin
        if (!afctrigger) begin
          state_d = AFC_IDLE;
        end else if (cmp_valid) begin
          if (cmp == CMP_EQ) begin
            state_d = AFC_DONE;
          end else begin
            if (cmp == CMP_DIV_FAST) code_d[k_q] = 1'b0;
            if (k_q != '0) begin
              code_d[k_q - 1'b1] = 1'b1;
              k_d      = k_q - 1'b1;
              state_d  = AFC_SETTLE;
              tmr_load = 1'b1;
            end else begin
              state_d = AFC_DONE;
            end
          end
        end
`ifdef AFC_TIMEOUT_EN
        else if (tmr_zero) begin
          state_d = AFC_DONE;
          fail_d  = 1'b1;
        end
`endif
      end
      AFC_DONE: begin
        if (!afctrigger) state_d = AFC_IDLE;
      end
      default: state_d = AFC_IDLE;
    endcase
  end

  always_comb begin
    meas_d   = (state_q == AFC_SETTLE) && (state_d == AFC_MEASURE);
    busy_d   = (state_d == AFC_SETTLE) || (state_d == AFC_MEASURE);
    status_d = (state_d == AFC_DONE) && !fail_d;
  end

  assign meas_start       = meas_q;
  assign control_code_out = code_q;
  assign afc_status       = status_q;
  assign afc_busy         = busy_q;
  assign afc_fail         = fail_q;

endmodule

// File: tb/tb_afc_bsearch_ctrl.sv
// Randomized bench for afc_bsearch_ctrl against an arithmetic model of the binary search.
module tb_afc_bsearch_ctrl;

  localparam int unsigned CW = 8;
  localparam int unsigned SC = 4;
  localparam int unsigned TC = 16;

  logic          refclk = 1'b0;
  logic          rst_n, afctrigger, cmp_valid, ref_fast, div_fast, eq;
  logic          meas_start, afc_status, afc_busy, afc_fail;
  logic [CW-1:0] control_code_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 refclk = ~refclk;

  afc_bsearch_ctrl #(
    .CODE_WIDTH     (CW),
    .SETTLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .refclk           (refclk),
    .rst_n            (rst_n),
    .afctrigger       (afctrigger),
    .cmp_valid        (cmp_valid),
    .ref_fast         (ref_fast),
    .div_fast         (div_fast),
    .eq               (eq),
    .meas_start       (meas_start),
    .control_code_out (control_code_out),
    .afc_status       (afc_status),
    .afc_busy         (afc_busy),
    .afc_fail         (afc_fail)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic int unsigned ctz(input int unsigned v);
    for (int i = 0; i < int'(CW); i++) if (v[i]) return i;
    return CW;
  endfunction

  // Code under test in window j (1-based): the top j-1 bits of the answer plus the trial bit.
  function automatic logic [31:0] win_code(input int unsigned fin, input int unsigned j);
    int unsigned keep_mask;
    keep_mask = ((1 << CW) - 1) & ~((1 << (CW - j + 1)) - 1);
    return (fin & keep_mask) | (1 << (CW - j));
  endfunction

  task automatic wait_meas(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (meas_start) ok = 1'b1;
    end
  endtask

  task automatic release_idle(input int unsigned exp_code);
    afctrigger = 1'b0;
    tick();
    check_eq("idle_status", afc_status, 0);
    check_eq("idle_busy", afc_busy, 0);
    check_eq("idle_code", control_code_out, exp_code);
  endtask

  // mode 0: comparator with target t; 1: always div_fast; 2: always ref_fast (or no flag).
  task automatic run_search(input int mode, input int unsigned t, input int unsigned abort_at);
    int unsigned fin, nwin, gap, windows, d, budget;
    bit          done;
    fin     = (mode == 0) ? t : (mode == 1) ? 0 : (1 << CW) - 1;
    nwin    = (mode == 0 && t != 0) ? CW - ctz(t) : CW;
    gap     = 0;
    windows = 0;
    budget  = 0;
    done    = 1'b0;
    afctrigger = 1'b1;
    while (!done && budget < 400) begin
      tick();
      gap++;
      budget++;
      if (meas_start) begin
        windows++;
        check_eq("meas_gap", gap, SC + 1);
        check_eq("win_code", control_code_out, win_code(fin, windows));
        check_eq("busy_meas", afc_busy, 1);
        check_eq("status_meas", afc_status, 0);
        d = $urandom_range(0, 3);
        repeat (d) tick();
        cmp_valid = 1'b1;
        if (abort_at == windows) begin
          afctrigger = 1'b0;
          div_fast   = 1'b1;
        end else if (mode == 1) begin
          div_fast = 1'b1;
        end else if (mode == 2) begin
          ref_fast = 1'($urandom_range(0, 1));
        end else if (control_code_out == t[CW-1:0]) begin
          eq       = 1'b1;
          div_fast = 1'($urandom_range(0, 1));
          ref_fast = 1'($urandom_range(0, 1));
        end else if (control_code_out > t[CW-1:0]) begin
          div_fast = 1'b1;
          ref_fast = 1'($urandom_range(0, 1));
        end else begin
          ref_fast = 1'($urandom_range(0, 1));
        end
        tick();
        cmp_valid = 1'b0;
        eq        = 1'b0;
        div_fast  = 1'b0;
        ref_fast  = 1'b0;
        gap       = 1;
        if (abort_at == windows) begin
          check_eq("abort_code", control_code_out, win_code(fin, windows));
          check_eq("abort_busy", afc_busy, 0);
          check_eq("abort_status", afc_status, 0);
          done = 1'b1;
        end else if (windows == nwin) begin
          check_eq("lock_status", afc_status, 1);
          check_eq("lock_code", control_code_out, fin);
          check_eq("lock_busy", afc_busy, 0);
          done = 1'b1;
        end else begin
          check_eq("upd_code", control_code_out, win_code(fin, windows + 1));
          check_eq("upd_status", afc_status, 0);
        end
      end else if (gap == 2) begin
        // Stray result while settling must be ignored.
        cmp_valid = 1'b1;
        eq        = 1'b1;
      end else if (gap == 3) begin
        cmp_valid = 1'b0;
        eq        = 1'b0;
      end
    end
    cmp_valid = 1'b0;
    eq        = 1'b0;
    check_eq("search_end", done, 1);
    check_eq("windows", windows, (abort_at != 0) ? abort_at : nwin);
  endtask

  initial begin : main
    int unsigned t;
    bit          ok;
    rst_n      = 1'b0;
    afctrigger = 1'b0;
    cmp_valid  = 1'b0;
    ref_fast   = 1'b0;
    div_fast   = 1'b0;
    eq         = 1'b0;
    #12;
    check_eq("rst_code", control_code_out, 32'h80);
    check_eq("rst_meas", meas_start, 0);
    check_eq("rst_status", afc_status, 0);
    check_eq("rst_busy", afc_busy, 0);
    check_eq("rst_fail", afc_fail, 0);
    rst_n = 1'b1;
    tick();

    run_search(0, 150, 0);  release_idle(150);
    run_search(0, 128, 0);  release_idle(128);
    run_search(1, 0, 0);    release_idle(0);
    run_search(2, 0, 0);    release_idle(255);
    run_search(0, 255, 0);  release_idle(255);
    run_search(0, 0, 0);    release_idle(0);
    for (int i = 0; i < 10; i++) begin
      t = $urandom_range(0, 255);
      run_search(0, t, 0);
      release_idle(t);
    end

    run_search(0, 1, 3);
    tick();
    check_eq("abort_hold", control_code_out, 32'h20);
    check_eq("abort_idle_busy", afc_busy, 0);
    t = $urandom_range(0, 255);
    run_search(0, t, 0);
    release_idle(t);

`ifdef AFC_TIMEOUT_EN
    afctrigger = 1'b1;
    wait_meas(ok);
    check_eq("to_meas_seen", ok, 1);
    repeat (TC - 1) tick();
    check_eq("to_fail_early", afc_fail, 0);
    tick();
    check_eq("to_fail", afc_fail, 1);
    check_eq("to_status", afc_status, 0);
    check_eq("to_code", control_code_out, 32'h80);
    check_eq("to_busy", afc_busy, 0);
    afctrigger = 1'b0;
    tick();
    check_eq("to_fail_idle", afc_fail, 1);
    afctrigger = 1'b1;
    tick();
    check_eq("to_fail_clr", afc_fail, 0);
    afctrigger = 1'b0;
    tick();
`else
    afctrigger = 1'b1;
    wait_meas(ok);
    check_eq("nto_meas_seen", ok, 1);
    repeat (40) tick();
    check_eq("nto_fail", afc_fail, 0);
    check_eq("nto_busy", afc_busy, 1);
    afctrigger = 1'b0;
    tick();
    check_eq("nto_idle", afc_busy, 0);
`endif

    afctrigger = 1'b1;
    wait_meas(ok);
    check_eq("rm_meas_seen", ok, 1);
    cmp_valid = 1'b1;
    div_fast  = 1'b1;
    tick();
    cmp_valid = 1'b0;
    div_fast  = 1'b0;
    check_eq("rm_upd", control_code_out, 32'h40);
    tick();
    check_eq("rm_busy", afc_busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rm_code", control_code_out, 32'h80);
    check_eq("rm_busy0", afc_busy, 0);
    check_eq("rm_status", afc_status, 0);
    check_eq("rm_meas", meas_start, 0);
    check_eq("rm_fail", afc_fail, 0);
    afctrigger = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    t = $urandom_range(0, 255);
    run_search(0, t, 0);
    release_idle(t);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
